bound_flasher_gen: RTL and testbench

Parametrised successor to the 16-lamp bound flasher. It drives a lamp bar of `NUM_LAMP` outputs through a six-phase fill/drain sequence with two programmable kickback bounds and optional mirrored lamp order. Compared with the fixed flasher it adds three things: a `hold` freeze input, `busy`/`done` status, and a completed-sequence counter. It sits between the panel control logic (which supplies `flick` and `hold`) and the lamp drivers.

---
 rtl/bound_flasher_gen.sv | 110 +++++++++++
 tb/tb_bound_flasher_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_gen.sv
// Parametrised bound flasher: six-phase fill/drain lamp bar with two kickback
// bounds, hold freeze, busy/done status and a completed-sequence counter.
module bound_flasher_gen #(
  parameter int NUM_LAMP = 16,
  parameter int KB1      = 6,
  parameter int KB2      = 11,
  parameter int MIRROR   = 0,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flick,
  input  logic                hold,
  output logic [NUM_LAMP-1:0] lamp,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    seq_cnt
);
  localparam int LW = $clog2(NUM_LAMP + 1);
  localparam logic [LW-1:0] L_KB1 = LW'(KB1);
  localparam logic [LW-1:0] L_KB2 = LW'(KB2);
  localparam logic [LW-1:0] L_N   = LW'(NUM_LAMP);

  typedef enum logic [2:0] {IDLE, UP1, DN1, UP2, DN2, UP3, DN3} state_t;

  state_t              state, state_nxt;
  logic [LW-1:0]       lvl, lvl_nxt, start_lvl, tgt_lvl;
  logic [NUM_LAMP-1:0] lamp_nxt;
  logic                kick, fin;

  always_comb begin
    start_lvl = '0;
    tgt_lvl   = '0;
    case (state)
      UP1:     begin start_lvl = '0;    tgt_lvl = L_KB1; end
      DN1:     begin start_lvl = L_KB1; tgt_lvl = '0;    end
      UP2:     begin start_lvl = '0;    tgt_lvl = L_KB2; end
      DN2:     begin start_lvl = L_KB2; tgt_lvl = L_KB1; end
      UP3:     begin start_lvl = L_KB1; tgt_lvl = L_N;   end
      DN3:     begin start_lvl = L_N;   tgt_lvl = '0;    end
      default: begin start_lvl = '0;    tgt_lvl = '0;    end
    endcase
  end

  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    kick      = 1'b0;
    fin       = 1'b0;
    if (!hold) begin
      case (state)
        IDLE: begin
          lvl_nxt = '0;
          if (flick) state_nxt = UP1;
        end
        UP1, UP2, UP3: begin
          // Kickback beats the target, so KB2 inside UP2 falls back to DN1.
          kick = (state != UP1) && (lvl == L_KB1 || lvl == L_KB2) &&
                 (lvl != start_lvl) && flick;
          if (kick)
            state_nxt = (state == UP2) ? DN1 : DN2;
          else if (lvl == tgt_lvl)
            state_nxt = (state == UP1) ? DN1 : (state == UP2) ? DN2 : DN3;
          else
            lvl_nxt = lvl + LW'(1);
        end
        DN1, DN2, DN3: begin
          if (lvl == tgt_lvl) begin
            state_nxt = (state == DN1) ? UP2 : (state == DN2) ? UP3 : IDLE;
            fin       = (state == DN3);
          end else begin
            lvl_nxt = lvl - LW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          lvl_nxt   = '0;
        end
      endcase
    end
  end

  // Lamps decode the next level so the lamp register tracks lvl exactly.
  for (genvar i = 0; i < NUM_LAMP; i++) begin : g_lamp
    localparam logic [LW-1:0] IDX = LW'(i);
    if (MIRROR != 0) begin : g_mir
      assign lamp_nxt[NUM_LAMP-1-i] = (IDX < lvl_nxt);
    end else begin : g_fwd
      assign lamp_nxt[i] = (IDX < lvl_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lvl     <= '0;
      lamp    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      seq_cnt <= '0;
    end else begin
      state <= state_nxt;
      lvl   <= lvl_nxt;
      lamp  <= lamp_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= fin;
      if (fin) seq_cnt <= seq_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_bound_flasher_gen.sv
// Directed bench for bound_flasher_gen: default instance plus a small mirrored one.
module tb_bound_flasher_gen;
  logic        clk = 1'b0;
  logic        rst, flick, hold;
  logic [15:0] lamp;
  logic        busy, done;
  logic [7:0]  seq_cnt;
  logic        rst2, flick2, hold2;
  logic [7:0]  lamp2;
  logic        busy2, done2;
  logic [1:0]  seq_cnt2;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  bound_flasher_gen dut (
    .clk(clk), .rst(rst), .flick(flick), .hold(hold),
    .lamp(lamp), .busy(busy), .done(done), .seq_cnt(seq_cnt)
  );

  bound_flasher_gen #(.NUM_LAMP(8), .KB1(2), .KB2(5), .MIRROR(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .flick(flick2), .hold(hold2),
    .lamp(lamp2), .busy(busy2), .done(done2), .seq_cnt(seq_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fill(input int l);
    logic [16:0] t;
    t = (17'd1 << l) - 17'd1;
    return t[15:0];
  endfunction

  // Expected levels after each edge of one phase: walk then one transition edge.
  task automatic seg(input int from, input int to);
    int l;
    l = from;
    while (l != to) begin
      l = (to > from) ? l + 1 : l - 1;
      exp_q.push_back(l);
    end
    exp_q.push_back(to);
  endtask

  initial begin
    rst = 1; flick = 0; hold = 0;
    rst2 = 1; flick2 = 0; hold2 = 0;
    step(); step();
    chk("rst_lamp", lamp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", seq_cnt, 0);
    rst = 0; rst2 = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_outs", {lamp, busy, done, seq_cnt}, 0);
    end

    // Full uninterrupted sequence
    flick = 1; step();
    chk("start_busy", busy, 1);
    chk("start_lamp", lamp, 0);
    flick = 0;
    seg(0, 6); seg(6, 0); seg(0, 11); seg(11, 6); seg(6, 16); seg(16, 0);
    chk("seq_len", exp_q.size(), 60);
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      chk("seq_lamp", lamp, fill(exp_q[i]));
      chk("seq_done", done, (i == exp_q.size() - 1));
      chk("seq_busy", busy, (i != exp_q.size() - 1));
    end
    chk("seq_cnt1", seq_cnt, 1);
    step();
    chk("done_one_cycle", done, 0);

    // Kickback at KB1 in UP2
    flick = 1; step(); flick = 0;
    repeat (14) step();
    repeat (6) step();
    chk("up2_at6", lamp, 16'h003F);
    flick = 1; step();
    chk("kb1_edge", lamp, 16'h003F);
    flick = 0; step();
    chk("kb1_dn1", lamp, 16'h001F);
    repeat (5) step();
    chk("kb1_dn1_zero", lamp, 0);
    step();
    chk("kb1_trans", lamp, 0);
    step();
    chk("kb1_up2_again", lamp, 16'h0001);
    repeat (10) step();
    chk("up2_peak", lamp, 16'h07FF);
    step();
    repeat (5) step();
    chk("dn2_end", lamp, 16'h003F);
    step();
    repeat (5) step();
    chk("up3_at11", lamp, 16'h07FF);
    // Kickback at KB2 in UP3
    flick = 1; step();
    chk("kb2_edge", lamp, 16'h07FF);
    flick = 0; step();
    chk("kb2_dn2", lamp, 16'h03FF);
    repeat (4) step();
    chk("kb2_dn2_end", lamp, 16'h003F);
    step();
    chk("kb2_trans", lamp, 16'h003F);
    step();
    chk("up3_resume", lamp, 16'h007F);
    repeat (2) step();
    chk("pre_hold", lamp, 16'h01FF);

    // Hold freezes everything, flick ignored
    hold = 1; flick = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_lamp", lamp, 16'h01FF);
      chk("hold_busy", busy, 1);
    end
    hold = 0; flick = 0; step();
    chk("post_hold", lamp, 16'h03FF);
    chk("post_hold_cnt", seq_cnt, 1);

    // Reset during DN3
    repeat (6) step();
    chk("up3_full", lamp, 16'hFFFF);
    step();
    repeat (3) step();
    chk("dn3_mid", lamp, 16'h1FFF);
    rst = 1; step();
    chk("midrst_lamp", lamp, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", seq_cnt, 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("midrst_noresume", {lamp, busy}, 0);
    end
    hold = 1; flick = 1; step();
    chk("hold_idle_busy", busy, 0);
    hold = 0; flick = 0; step();

    // Mirrored small instance, five back-to-back sequences
    for (int k = 0; k < 5; k++) begin
      int  n;
      bit  saw_full;
      n = 0; saw_full = 0;
      flick2 = 1; step(); flick2 = 0;
      for (int t = 0; t < 64; t++) begin
        step();
        n++;
        if (k == 0 && n == 1) chk("gen_first_lamp", lamp2, 8'h80);
        if (lamp2 == 8'hFF) saw_full = 1;
        if (done2) break;
      end
      chk("gen_len", n, 32);
      chk("gen_peak", saw_full, 1);
      chk("gen_cnt", seq_cnt2, (k + 1) % 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
